// File: rtl/imem_prog_encoder_pkg.sv
// Shared instruction-encoding constants for the program loader and the CPU decoder.
// Contents: field positions, opcode/funct codes, mnemonic index enum, loader FSM
// states, and encode_instr() which turns a symbolic record into a 32-bit word.
package imem_prog_encoder_pkg;

    // Field LSB positions within a 32-bit instruction word
    localparam int unsigned OpPos = 26;
    localparam int unsigned RsPos = 21;
    localparam int unsigned RtPos = 16;
    localparam int unsigned RdPos = 11;
    localparam int unsigned SaPos = 6;

    // Opcodes
    localparam logic [5:0] OpRType = 6'b000000;
    localparam logic [5:0] OpAddi  = 6'b001000;
    localparam logic [5:0] OpAndi  = 6'b001100;
    localparam logic [5:0] OpOri   = 6'b001101;
    localparam logic [5:0] OpXori  = 6'b001110;
    localparam logic [5:0] OpLw    = 6'b100011;
    localparam logic [5:0] OpSw    = 6'b101011;
    localparam logic [5:0] OpBeq   = 6'b000100;
    localparam logic [5:0] OpBne   = 6'b000101;
    localparam logic [5:0] OpLui   = 6'b001111;
    localparam logic [5:0] OpJ     = 6'b000010;
    localparam logic [5:0] OpJal   = 6'b000011;

    // R-type funct codes
    localparam logic [5:0] FnAdd  = 6'b100000;
    localparam logic [5:0] FnSub  = 6'b100010;
    localparam logic [5:0] FnAnd  = 6'b100100;
    localparam logic [5:0] FnOr   = 6'b100101;
    localparam logic [5:0] FnXor  = 6'b100110;
    localparam logic [5:0] FnSll  = 6'b000000;
    localparam logic [5:0] FnSrl  = 6'b000010;
    localparam logic [5:0] FnSra  = 6'b000011;
    localparam logic [5:0] FnJr   = 6'b001000;
    localparam logic [5:0] FnHamd = 6'b011000;
    localparam logic [5:0] FnDiv  = 6'b011010;
    localparam logic [5:0] FnSlt  = 6'b101010;
    localparam logic [5:0] FnEven = 6'b111111;

    typedef enum logic [4:0] {
        MnAdd, MnSub, MnAnd, MnOr, MnXor, MnSll, MnSrl, MnSra,
        MnJr, MnHamd, MnDiv, MnSlt, MnEven,
        MnAddi, MnAndi, MnOri, MnXori, MnLw, MnSw, MnBeq, MnBne, MnLui,
        MnJ, MnJal
    } mnem_e;

    // Indices at or above this are illegal
    localparam logic [4:0] NumMnem = 5'd24;

    typedef enum logic [1:0] {StIdle, StLoad, StFlush, StDone} state_e;

    function automatic logic [31:0] encode_instr(
        input logic [4:0]  mnem,
        input logic [4:0]  rs,
        input logic [4:0]  rt,
        input logic [4:0]  rd,
        input logic [4:0]  sa,
        input logic [15:0] imm,
        input logic [25:0] target
    );
        logic [5:0]  op;
        logic [5:0]  funct;
        logic [4:0]  rs_f;
        logic [4:0]  rt_f;
        logic [4:0]  rd_f;
        logic [4:0]  sa_f;
        logic [31:0] word;
        op    = OpRType;
        funct = '0;
        rs_f  = rs;
        rt_f  = rt;
        rd_f  = rd;
        sa_f  = '0;
        case (mnem_e'(mnem))
            MnAdd:  funct = FnAdd;
            MnSub:  funct = FnSub;
            MnAnd:  funct = FnAnd;
            MnOr:   funct = FnOr;
            MnXor:  funct = FnXor;
            MnSll:  begin funct = FnSll; rs_f = '0; sa_f = sa; end
            MnSrl:  begin funct = FnSrl; rs_f = '0; sa_f = sa; end
            MnSra:  begin funct = FnSra; rs_f = '0; sa_f = sa; end
            MnJr:   begin funct = FnJr; rt_f = '0; rd_f = '0; end
            MnHamd: funct = FnHamd;
            MnDiv:  funct = FnDiv;
            MnSlt:  funct = FnSlt;
            MnEven: funct = FnEven;
            MnAddi: op = OpAddi;
            MnAndi: op = OpAndi;
            MnOri:  op = OpOri;
            MnXori: op = OpXori;
            MnLw:   op = OpLw;
            MnSw:   op = OpSw;
            MnBeq:  op = OpBeq;
            MnBne:  op = OpBne;
            MnLui:  begin op = OpLui; rs_f = '0; end
            MnJ:    op = OpJ;
            MnJal:  op = OpJal;
            default: ;
        endcase
        if (mnem >= NumMnem) begin
            word = '0;
        end else if (mnem <= MnEven) begin
            word = (32'(op) << OpPos) | (32'(rs_f) << RsPos) | (32'(rt_f) << RtPos)
                 | (32'(rd_f) << RdPos) | (32'(sa_f) << SaPos) | 32'(funct);
        end else if (mnem <= MnLui) begin
            word = (32'(op) << OpPos) | (32'(rs_f) << RsPos) | (32'(rt_f) << RtPos)
                 | 32'(imm);
        end else begin
            word = (32'(op) << OpPos) | 32'(target);
        end
        return word;
    endfunction

endpackage

// File: rtl/imem_prog_encoder_fifo.sv
// prog_fifo: synchronous FIFO for encoded instruction words.
// Ports: clock/resetn (async active-low), clear_i drops all contents, push_i/wdata_i
// write, pop_i/rdata_o read (rdata_o is the registered head entry), full_o/empty_o.
// A push while full is accepted only if a pop happens in the same cycle.
module prog_fifo #(
    parameter int unsigned FIFO_DEPTH = 4,
    parameter int unsigned Width      = 32
) (
    input  logic             clock,
    input  logic             resetn,
    input  logic             clear_i,
    input  logic             push_i,
    input  logic [Width-1:0] wdata_i,
    input  logic             pop_i,
    output logic [Width-1:0] rdata_o,
    output logic             full_o,
    output logic             empty_o
);
    localparam int unsigned PtrW = $clog2(FIFO_DEPTH);

    logic [Width-1:0] mem_q [FIFO_DEPTH];
    logic [PtrW:0]    wptr_q, wptr_d;
    logic [PtrW:0]    rptr_q, rptr_d;
    logic             do_push, do_pop;

    // Extra pointer MSB distinguishes full from empty
    assign empty_o = (wptr_q == rptr_q);
    assign full_o  = (wptr_q[PtrW] != rptr_q[PtrW]) && (wptr_q[PtrW-1:0] == rptr_q[PtrW-1:0]);
    assign do_pop  = pop_i & ~empty_o;
    assign do_push = push_i & (~full_o | do_pop);
    assign rdata_o = mem_q[rptr_q[PtrW-1:0]];

    always_comb begin
        wptr_d = wptr_q;
        rptr_d = rptr_q;
        if (clear_i) begin
            wptr_d = '0;
            rptr_d = '0;
        end else begin
            if (do_push) wptr_d = wptr_q + 1'b1;
            if (do_pop)  rptr_d = rptr_q + 1'b1;
        end
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            wptr_q <= '0;
            rptr_q <= '0;
        end else begin
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
        end
    end

    always_ff @(posedge clock) begin
        if (do_push && !clear_i) mem_q[wptr_q[PtrW-1:0]] <= wdata_i;
    end

endmodule

// File: rtl/imem_prog_encoder.sv
// imem_prog_encoder: program-loader front end. Encodes symbolic instruction records
// (valid/ready) into MIPS words, buffers them in prog_fifo and writes them to
// instruction memory at consecutive addresses starting from BASE_ADDR.
// Ports: clock/resetn, start/finish session pulses, in_* record handshake and fields,
// imem_we/addr/wdata write port held while imem_gnt is low, busy/done/word_count
// status, sticky err_illegal/err_overflow.
module imem_prog_encoder
    import imem_prog_encoder_pkg::*;
#(
    parameter int unsigned ADDR_W     = 10,
    parameter int unsigned MEM_WORDS  = 1024,
    parameter int unsigned BASE_ADDR  = 0,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic              clock,
    input  logic              resetn,
    input  logic              start,
    input  logic              finish,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [4:0]        in_mnem,
    input  logic [4:0]        in_rs,
    input  logic [4:0]        in_rt,
    input  logic [4:0]        in_rd,
    input  logic [4:0]        in_sa,
    input  logic [15:0]       in_imm,
    input  logic [25:0]       in_target,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [31:0]       imem_wdata,
    input  logic              imem_gnt,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W:0]   word_count,
    output logic              err_illegal,
    output logic              err_overflow
);
    localparam logic [ADDR_W-1:0] BaseAddr = ADDR_W'(BASE_ADDR);
    localparam logic [ADDR_W-1:0] LastAddr = ADDR_W'(BASE_ADDR + MEM_WORDS - 1);

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [ADDR_W:0]   count_q, count_d;
    logic              err_ill_q, err_ill_d;
    logic              err_ovf_q, err_ovf_d;

    logic        accept, legal, push, wr_done, enter_load, fifo_clear;
    logic        fifo_full, fifo_empty;
    logic [31:0] fifo_rdata, enc_word;

    assign in_ready = (state_q == StLoad) & ~fifo_full & ~err_ovf_q;
    assign accept   = in_valid & in_ready;
    assign legal    = (in_mnem < NumMnem);
    assign push     = accept & legal;
    assign enc_word = encode_instr(in_mnem, in_rs, in_rt, in_rd, in_sa, in_imm, in_target);

    assign imem_we    = ~fifo_empty & ~err_ovf_q;
    assign wr_done    = imem_we & imem_gnt;
    assign imem_addr  = addr_q;
    assign imem_wdata = imem_we ? fifo_rdata : '0;

    // Completing the last writable word discards whatever is still buffered
    assign fifo_clear = enter_load | (wr_done & (addr_q == LastAddr));

    prog_fifo #(
        .FIFO_DEPTH (FIFO_DEPTH),
        .Width      (32)
    ) u_fifo (
        .clock   (clock),
        .resetn  (resetn),
        .clear_i (fifo_clear),
        .push_i  (push),
        .wdata_i (enc_word),
        .pop_i   (wr_done),
        .rdata_o (fifo_rdata),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        count_d    = count_q;
        err_ill_d  = err_ill_q;
        err_ovf_d  = err_ovf_q;
        enter_load = 1'b0;

        if (accept && !legal) err_ill_d = 1'b1;
        if (wr_done) begin
            count_d = count_q + 1'b1;
            // Address saturates at the last word rather than wrapping
            if (addr_q == LastAddr) err_ovf_d = 1'b1;
            else                    addr_d    = addr_q + 1'b1;
        end

        unique case (state_q)
            StIdle, StDone: begin
                if (start) begin
                    state_d    = StLoad;
                    enter_load = 1'b1;
                    addr_d     = BaseAddr;
                    count_d    = '0;
                    err_ill_d  = 1'b0;
                    err_ovf_d  = 1'b0;
                end
            end
            StLoad: begin
                if (finish) state_d = StFlush;
            end
            StFlush: begin
                // Empty FIFO implies no write is pending
                if (fifo_empty) state_d = StDone;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state_q   <= StIdle;
            addr_q    <= BaseAddr;
            count_q   <= '0;
            err_ill_q <= 1'b0;
            err_ovf_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            count_q   <= count_d;
            err_ill_q <= err_ill_d;
            err_ovf_q <= err_ovf_d;
        end
    end

    assign busy         = (state_q == StLoad) | (state_q == StFlush);
    assign done         = (state_q == StDone);
    assign word_count   = count_q;
    assign err_illegal  = err_ill_q;
    assign err_overflow = err_ovf_q;

endmodule

// File: tb/tb_imem_prog_encoder.sv
// Self-checking bench for imem_prog_encoder: directed sessions plus a randomized
// session, all written words compared against a table-driven reference encoder.
// A second instance with MEM_WORDS=4 exercises memory overflow.
module tb_imem_prog_encoder;
    localparam int AW = 10;

    logic          clock = 1'b0;
    logic          resetn = 1'b0;
    logic          start = 1'b0, finish = 1'b0, in_valid = 1'b0;
    logic [4:0]    in_mnem = '0, in_rs = '0, in_rt = '0, in_rd = '0, in_sa = '0;
    logic [15:0]   in_imm = '0;
    logic [25:0]   in_target = '0;
    logic          imem_gnt;
    logic          gnt_dir = 1'b1, gnt_rnd = 1'b1;
    bit            gnt_rand = 1'b0;

    logic          in_ready, imem_we, busy, done, err_illegal, err_overflow;
    logic [AW-1:0] imem_addr;
    logic [31:0]   imem_wdata;
    logic [AW:0]   word_count;

    logic          o_in_ready, o_imem_we, o_busy, o_done, o_err_illegal, o_err_overflow;
    logic [AW-1:0] o_imem_addr;
    logic [31:0]   o_imem_wdata;
    logic [AW:0]   o_word_count;

    assign imem_gnt = gnt_rand ? gnt_rnd : gnt_dir;

    imem_prog_encoder dut (
        .clock(clock), .resetn(resetn), .start(start), .finish(finish),
        .in_valid(in_valid), .in_ready(in_ready), .in_mnem(in_mnem), .in_rs(in_rs),
        .in_rt(in_rt), .in_rd(in_rd), .in_sa(in_sa), .in_imm(in_imm),
        .in_target(in_target), .imem_we(imem_we), .imem_addr(imem_addr),
        .imem_wdata(imem_wdata), .imem_gnt(imem_gnt), .busy(busy), .done(done),
        .word_count(word_count), .err_illegal(err_illegal), .err_overflow(err_overflow)
    );

    imem_prog_encoder #(.MEM_WORDS(4)) dut_ovf (
        .clock(clock), .resetn(resetn), .start(start), .finish(finish),
        .in_valid(in_valid), .in_ready(o_in_ready), .in_mnem(in_mnem), .in_rs(in_rs),
        .in_rt(in_rt), .in_rd(in_rd), .in_sa(in_sa), .in_imm(in_imm),
        .in_target(in_target), .imem_we(o_imem_we), .imem_addr(o_imem_addr),
        .imem_wdata(o_imem_wdata), .imem_gnt(imem_gnt), .busy(o_busy), .done(o_done),
        .word_count(o_word_count), .err_illegal(o_err_illegal),
        .err_overflow(o_err_overflow)
    );

    always #5 clock = ~clock;

    int checks = 0;
    int errors = 0;

    // Reference tables indexed by mnemonic
    int unsigned fn_tab [13] = '{32, 34, 36, 37, 38, 0, 2, 3, 8, 24, 26, 42, 63};
    int unsigned op_tab [11] = '{8, 12, 13, 14, 35, 43, 4, 5, 15, 2, 3};

    logic [31:0]   exp_q [$];
    logic          exp_ill;
    logic [AW-1:0] cap_a [$];
    logic [31:0]   cap_d [$];
    logic [AW-1:0] ocap_a [$];
    logic [31:0]   ocap_d [$];
    logic          pend_q = 1'b0;
    logic [AW-1:0] pend_a = '0;
    logic [31:0]   pend_d = '0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] model(input int m, input int rs, input int rt,
                                          input int rd, input int sa, input int imm,
                                          input int tg);
        longint unsigned w;
        bit shift;
        shift = (m >= 5 && m <= 7);
        if (m < 13) begin
            if (shift) rs = 0;
            if (m == 8) begin rt = 0; rd = 0; sa = 0; end
            else if (!shift) sa = 0;
            w = rs * 2097152 + rt * 65536 + rd * 2048 + sa * 64 + fn_tab[m];
        end else if (m < 22) begin
            if (m == 21) rs = 0;
            w = longint'(op_tab[m-13]) * 67108864 + rs * 2097152 + rt * 65536 + imm;
        end else begin
            w = longint'(op_tab[m-13]) * 67108864 + tg;
        end
        return w[31:0];
    endfunction

    always @(negedge clock) gnt_rnd <= ($urandom_range(0, 3) != 0);

    // Write-port monitor, plus hold check while the grant is low
    always @(posedge clock) begin
        if (imem_we === 1'b1 && imem_gnt === 1'b1) begin
            cap_a.push_back(imem_addr);
            cap_d.push_back(imem_wdata);
        end
        if (o_imem_we === 1'b1 && imem_gnt === 1'b1) begin
            ocap_a.push_back(o_imem_addr);
            ocap_d.push_back(o_imem_wdata);
        end
        if (pend_q && resetn) chk("hold", {imem_we, imem_addr, imem_wdata}, {1'b1, pend_a, pend_d});
        pend_q <= resetn && (imem_we === 1'b1) && (imem_gnt === 1'b0);
        pend_a <= imem_addr;
        pend_d <= imem_wdata;
    end

    task automatic send(input int m, input int rs, input int rt, input int rd,
                        input int sa, input int imm, input int tg);
        int n = 0;
        in_mnem = 5'(m); in_rs = 5'(rs); in_rt = 5'(rt); in_rd = 5'(rd); in_sa = 5'(sa);
        in_imm = 16'(imm); in_target = 26'(tg);
        in_valid = 1'b1;
        while (in_ready !== 1'b1 && n < 300) begin @(negedge clock); n++; end
        chk("accept", in_ready, 1);
        @(negedge clock);
        in_valid = 1'b0;
        if (m < 24) exp_q.push_back(model(m, rs, rt, rd, sa, imm, tg));
        else exp_ill = 1'b1;
    endtask

    task automatic send_rand(input int m);
        send(m, $urandom_range(0, 31), $urandom_range(0, 31), $urandom_range(0, 31),
             $urandom_range(0, 31), $urandom_range(0, 65535), $urandom_range(0, 67108863));
    endtask

    task automatic begin_session();
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        exp_q.delete(); cap_a.delete(); cap_d.delete(); ocap_a.delete(); ocap_d.delete();
        exp_ill = 1'b0;
    endtask

    task automatic end_session();
        int n = 0;
        finish = 1'b1;
        @(negedge clock);
        finish = 1'b0;
        while (done !== 1'b1 && n < 400) begin @(negedge clock); n++; end
        chk("done", done, 1);
        chk("busy_done", busy, 0);
    endtask

    task automatic compare(input string tag);
        int n;
        n = (cap_d.size() < exp_q.size()) ? cap_d.size() : exp_q.size();
        chk({tag, "_nwords"}, cap_d.size(), exp_q.size());
        for (int i = 0; i < n; i++) begin
            chk($sformatf("%s_addr%0d", tag, i), cap_a[i], i);
            chk($sformatf("%s_data%0d", tag, i), cap_d[i], exp_q[i]);
        end
        chk({tag, "_count"}, word_count, exp_q.size());
        chk({tag, "_illegal"}, err_illegal, exp_ill);
    endtask

    task automatic lit(input int i, input logic [31:0] v);
        chk($sformatf("lit%0d", i), (cap_d.size() > i) ? cap_d[i] : 32'hdead_beef, v);
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_ready"}, in_ready, 0);
        chk({tag, "_we"}, imem_we, 0);
        chk({tag, "_addr"}, imem_addr, 0);
        chk({tag, "_wdata"}, imem_wdata, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_done"}, done, 0);
        chk({tag, "_count"}, word_count, 0);
        chk({tag, "_errs"}, {err_illegal, err_overflow}, 0);
    endtask

    initial begin
        int rm [6];
        int rf [6][6];
        int idx;
        int n;

        repeat (2) @(negedge clock);
        chk_reset_outputs("rst");
        resetn = 1'b1;
        @(negedge clock);

        // Single add
        begin_session();
        chk("busy_load", busy, 1);
        send(0, 1, 2, 3, 0, 0, 0);
        end_session();
        lit(0, 32'h0022_1820);
        compare("add");

        // sll (rs forced 0), lw, j
        begin_session();
        send(5, 7, 1, 2, 3, 0, 0);
        send(17, 1, 5, 0, 0, 4, 0);
        send(22, 0, 0, 0, 0, 0, 'h40);
        end_session();
        lit(0, 32'h0001_10C0);
        lit(1, 32'h8C25_0004);
        lit(2, 32'h0800_0040);
        compare("mix");

        // Grant held low: FIFO fills after four records
        for (int i = 0; i < 6; i++) begin
            rm[i] = $urandom_range(0, 23);
            for (int j = 0; j < 6; j++) rf[i][j] = $urandom_range(0, 65535);
        end
        gnt_dir = 1'b0;
        begin_session();
        idx = 0;
        for (int c = 0; c < 6; c++) begin
            in_mnem = 5'(rm[idx]); in_rs = 5'(rf[idx][0]); in_rt = 5'(rf[idx][1]);
            in_rd = 5'(rf[idx][2]); in_sa = 5'(rf[idx][3]); in_imm = 16'(rf[idx][4]);
            in_target = 26'(rf[idx][5]);
            in_valid = 1'b1;
            if (in_ready === 1'b1) begin
                exp_q.push_back(model(rm[idx], rf[idx][0] % 32, rf[idx][1] % 32,
                                      rf[idx][2] % 32, rf[idx][3] % 32, rf[idx][4],
                                      rf[idx][5]));
                idx++;
            end
            @(negedge clock);
        end
        chk("stall_accepts", idx, 4);
        chk("stall_ready", in_ready, 0);
        chk("stall_we", imem_we, 1);
        chk("stall_addr", imem_addr, 0);
        chk("stall_head", imem_wdata, exp_q[0]);
        chk("stall_nowrite", cap_d.size(), 0);
        gnt_dir = 1'b1;
        for (int i = 4; i < 6; i++)
            send(rm[i], rf[i][0] % 32, rf[i][1] % 32, rf[i][2] % 32, rf[i][3] % 32,
                 rf[i][4], rf[i][5]);
        end_session();
        compare("stall");

        // Illegal mnemonic between two valid records
        begin_session();
        send_rand(3);
        send_rand(25);
        send_rand(11);
        end_session();
        compare("illegal");

        // Overflow on the MEM_WORDS=4 instance
        begin_session();
        for (int i = 0; i < 6; i++) send_rand($urandom_range(0, 23));
        repeat (3) @(negedge clock);
        chk("ovf_err", o_err_overflow, 1);
        chk("ovf_ready", o_in_ready, 0);
        chk("ovf_we", o_imem_we, 0);
        chk("ovf_addr", o_imem_addr, 3);
        chk("ovf_busy", o_busy, 1);
        chk("ovf_notdone", o_done, 0);
        finish = 1'b1;
        @(negedge clock);
        finish = 1'b0;
        n = 0;
        while (o_done !== 1'b1 && n < 50) begin @(negedge clock); n++; end
        chk("ovf_done", o_done, 1);
        chk("ovf_count", o_word_count, 4);
        chk("ovf_illegal", o_err_illegal, 0);
        chk("ovf_nwords", ocap_d.size(), 4);
        for (int i = 0; i < 4 && i < ocap_d.size(); i++) begin
            chk($sformatf("ovf_addr%0d", i), ocap_a[i], i);
            chk($sformatf("ovf_data%0d", i), ocap_d[i], exp_q[i]);
        end
        n = 0;
        while (done !== 1'b1 && n < 50) begin @(negedge clock); n++; end
        chk("ovf_main_done", done, 1);

        // Randomized session with a random grant
        gnt_rand = 1'b1;
        begin_session();
        for (int i = 0; i < 30; i++) send_rand($urandom_range(0, 27));
        end_session();
        gnt_rand = 1'b0;
        @(negedge clock);
        compare("rand");

        // Reset in the middle of a session
        begin_session();
        send_rand(1);
        send_rand(14);
        repeat (2) @(negedge clock);
        chk("pre_rst_addr", imem_addr, 2);
        resetn = 1'b0;
        #1;
        chk_reset_outputs("midrst");
        @(negedge clock);
        resetn = 1'b1;
        @(negedge clock);
        begin_session();
        send_rand(23);
        end_session();
        compare("restart");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
